// File: rtl/cp0_regs_pkg.sv
// Shared widths, CP0 register numbers, exception type codes and Status/Cause
// bit positions for the coprocessor-0 register file.
package cp0_regs_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned INT_W      = 6;
    localparam int unsigned EXC_CODE_W = 5;

    localparam logic [REG_ADDR_W-1:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_EPC      = 5'd14;

    typedef enum logic [DATA_W-1:0] {
        EXC_NONE = 32'h0000_0000,
        EXC_INT  = 32'h0000_0001,
        EXC_ADEL = 32'h0000_0004,
        EXC_ADES = 32'h0000_0005,
        EXC_SYS  = 32'h0000_0008,
        EXC_BP   = 32'h0000_0009,
        EXC_RI   = 32'h0000_000A,
        EXC_OV   = 32'h0000_000C,
        EXC_ERET = 32'h0000_000E
    } exc_type_e;

    localparam int unsigned STATUS_IE     = 0;
    localparam int unsigned STATUS_EXL    = 1;
    localparam int unsigned STATUS_IM_LSB = 8;
    localparam int unsigned STATUS_IM_MSB = 15;

    localparam int unsigned CAUSE_EXC_LSB   = 2;
    localparam int unsigned CAUSE_EXC_MSB   = 6;
    localparam int unsigned CAUSE_IP_SW_LSB = 8;
    localparam int unsigned CAUSE_IP_SW_MSB = 9;
    localparam int unsigned CAUSE_IP_HW_LSB = 10;
    localparam int unsigned CAUSE_IP_HW_MSB = 15;
    localparam int unsigned CAUSE_BD        = 31;

    // Interrupts report ExcCode 0; every other committed code uses its low bits.
    function automatic logic [EXC_CODE_W-1:0] exc_code(input logic [DATA_W-1:0] etype);
        return (etype == DATA_W'(EXC_INT)) ? '0 : etype[EXC_CODE_W-1:0];
    endfunction

endpackage

// File: rtl/cp0_regs_if.sv
// mtc0/mfc0, exception-commit and register-image signals between the pipeline
// (master) and the CP0 register file (slave).
interface cp0_regs_if;
    import cp0_regs_pkg::*;

    logic                  we_i;
    logic [REG_ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic [REG_ADDR_W-1:0] raddr_i;
    logic [INT_W-1:0]      int_i;
    logic [DATA_W-1:0]     excepttype_i;
    logic [DATA_W-1:0]     pc_i;
    logic                  is_in_delayslot_i;
    logic [DATA_W-1:0]     bad_addr_i;

    logic [DATA_W-1:0]     rdata_o;
    logic [DATA_W-1:0]     count_o;
    logic [DATA_W-1:0]     compare_o;
    logic [DATA_W-1:0]     status_o;
    logic [DATA_W-1:0]     cause_o;
    logic [DATA_W-1:0]     epc_o;
    logic [DATA_W-1:0]     badvaddr_o;
    logic                  timer_int_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, int_i,
               excepttype_i, pc_i, is_in_delayslot_i, bad_addr_i,
        input  rdata_o, count_o, compare_o, status_o, cause_o,
               epc_o, badvaddr_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, int_i,
               excepttype_i, pc_i, is_in_delayslot_i, bad_addr_i,
        output rdata_o, count_o, compare_o, status_o, cause_o,
               epc_o, badvaddr_o, timer_int_o
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: clock prescaler, free-running Count, and the sticky
// timer interrupt raised on a nonzero Compare match.
module cp0_timer
    import cp0_regs_pkg::*;
#(
    parameter int unsigned COUNT_DIV_LOG2 = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              count_we,
    input  logic              compare_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              timer_int
);

    localparam int unsigned PRE_W = (COUNT_DIV_LOG2 == 0) ? 1 : COUNT_DIV_LOG2;

    logic [PRE_W-1:0]  presc_q;
    logic [PRE_W-1:0]  presc_d;
    logic [DATA_W-1:0] count_d;
    logic [DATA_W-1:0] compare_d;
    logic              timer_int_d;
    logic              wrap_c;
    logic              match_c;

    assign wrap_c  = (COUNT_DIV_LOG2 == 0) || (presc_q == {PRE_W{1'b1}});
    assign match_c = (count == compare) && (compare != '0);

    // An mtc0 to Count overrides the prescaler tick; a Compare write beats a match.
    always_comb begin
        presc_d     = wrap_c ? '0 : presc_q + PRE_W'(1);
        count_d     = wrap_c ? count + DATA_W'(1) : count;
        compare_d   = compare;
        timer_int_d = timer_int | match_c;
        if (count_we) begin
            presc_d = '0;
            count_d = wdata;
        end
        if (compare_we) begin
            compare_d   = wdata;
            timer_int_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count     <= count_d;
            compare   <= compare_d;
            timer_int <= timer_int_d;
        end
    end

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC,
// mtc0 writes, mfc0 reads and exception/eret commit from the M-stage classifier.
module cp0_regs
    import cp0_regs_pkg::*;
#(
    parameter int unsigned       COUNT_DIV_LOG2 = 1,
    parameter logic [DATA_W-1:0] STATUS_RST     = 32'h0040_0000
) (
    input logic       clk,
    input logic       resetn,
    cp0_regs_if.slave cp0
);

    logic [DATA_W-1:0] status_q,   status_d;
    logic [DATA_W-1:0] cause_q,    cause_d;
    logic [DATA_W-1:0] epc_q,      epc_d;
    logic [DATA_W-1:0] badvaddr_q, badvaddr_d;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;
    logic              timer_int;

    logic exc_c;
    logic eret_c;
    logic addr_exc_c;
    logic we_count_c;
    logic we_compare_c;
    logic we_status_c;
    logic we_cause_c;
    logic we_epc_c;

    assign eret_c       = cp0.excepttype_i == DATA_W'(EXC_ERET);
    assign exc_c        = (cp0.excepttype_i != DATA_W'(EXC_NONE)) && !eret_c;
    assign addr_exc_c   = (cp0.excepttype_i == DATA_W'(EXC_ADEL)) ||
                          (cp0.excepttype_i == DATA_W'(EXC_ADES));
    assign we_count_c   = cp0.we_i && (cp0.waddr_i == CP0_REG_COUNT);
    assign we_compare_c = cp0.we_i && (cp0.waddr_i == CP0_REG_COMPARE);
    assign we_status_c  = cp0.we_i && (cp0.waddr_i == CP0_REG_STATUS);
    assign we_cause_c   = cp0.we_i && (cp0.waddr_i == CP0_REG_CAUSE);
    assign we_epc_c     = cp0.we_i && (cp0.waddr_i == CP0_REG_EPC);

    cp0_timer #(
        .COUNT_DIV_LOG2 (COUNT_DIV_LOG2)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (we_count_c),
        .compare_we (we_compare_c),
        .wdata      (cp0.wdata_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );

    // mtc0 applies first; exception/eret then override only the fields they own.
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (we_status_c) begin
            status_d[STATUS_IM_MSB:STATUS_IM_LSB] = cp0.wdata_i[STATUS_IM_MSB:STATUS_IM_LSB];
            status_d[STATUS_EXL]                  = cp0.wdata_i[STATUS_EXL];
            status_d[STATUS_IE]                   = cp0.wdata_i[STATUS_IE];
        end
        if (we_cause_c) begin
            cause_d[CAUSE_IP_SW_MSB:CAUSE_IP_SW_LSB] = cp0.wdata_i[CAUSE_IP_SW_MSB:CAUSE_IP_SW_LSB];
        end
        if (we_epc_c) begin
            epc_d = cp0.wdata_i;
        end

        cause_d[CAUSE_IP_HW_MSB:CAUSE_IP_HW_LSB] = {cp0.int_i[INT_W-1] | timer_int,
                                                   cp0.int_i[INT_W-2:0]};

        if (exc_c) begin
            status_d[STATUS_EXL]                 = 1'b1;
            cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code(cp0.excepttype_i);
            // A nested exception keeps the EPC/BD of the original one.
            if (!status_q[STATUS_EXL]) begin
                epc_d            = cp0.is_in_delayslot_i ? cp0.pc_i - DATA_W'(4) : cp0.pc_i;
                cause_d[CAUSE_BD] = cp0.is_in_delayslot_i;
            end
            if (addr_exc_c) begin
                badvaddr_d = cp0.bad_addr_i;
            end
        end else if (eret_c) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // mfc0 reads current state; same-cycle writes are forwarded by the classifier.
    always_comb begin
        cp0.rdata_o = '0;
        case (cp0.raddr_i)
            CP0_REG_BADVADDR: cp0.rdata_o = badvaddr_q;
            CP0_REG_COUNT:    cp0.rdata_o = count;
            CP0_REG_COMPARE:  cp0.rdata_o = compare;
            CP0_REG_STATUS:   cp0.rdata_o = status_q;
            CP0_REG_CAUSE:    cp0.rdata_o = cause_q;
            CP0_REG_EPC:      cp0.rdata_o = epc_q;
            default:          cp0.rdata_o = '0;
        endcase
    end

    assign cp0.count_o     = count;
    assign cp0.compare_o   = compare;
    assign cp0.status_o    = status_q;
    assign cp0.cause_o     = cause_q;
    assign cp0.epc_o       = epc_q;
    assign cp0.badvaddr_o  = badvaddr_q;
    assign cp0.timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs: field-level reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_cp0_regs;

    localparam int unsigned N       = 1;
    localparam logic [31:0] ST_RST  = 32'h0040_0000;
    localparam logic [31:0] ST_MASK = 32'h0000_FF03;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   ridx   = 0;
    logic [4:0] rlist [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd10, 5'd31};

    cp0_regs_if bus();

    cp0_regs #(
        .COUNT_DIV_LOG2 (N),
        .STATUS_RST     (ST_RST)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .cp0    (bus)
    );

    always #5 clk = ~clk;

    // Reference state kept per architectural field.
    logic [31:0] m_status, m_epc, m_bad, m_compare, m_base, st_tmp;
    longint      m_ticks;
    logic        m_tint, m_bd;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_ticks >> N);
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, 15'b0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit wr(input logic [4:0] a);
        return bus.we_i && (bus.waddr_i == a);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_status <= ST_RST; m_epc <= '0; m_bad <= '0; m_compare <= '0;
            m_base <= '0; m_ticks <= 0; m_tint <= 1'b0; m_bd <= 1'b0;
            m_exc <= '0; m_ipsw <= '0; m_iphw <= '0;
        end else begin
            if (wr(5'd9)) begin
                m_base  <= bus.wdata_i;
                m_ticks <= 0;
            end else begin
                m_ticks <= m_ticks + 1;
            end
            if (wr(5'd11)) begin
                m_compare <= bus.wdata_i;
                m_tint    <= 1'b0;
            end else if (m_count() == m_compare && m_compare != 0) begin
                m_tint <= 1'b1;
            end
            m_iphw <= {bus.int_i[5] | m_tint, bus.int_i[4:0]};
            if (wr(5'd13)) m_ipsw <= bus.wdata_i[9:8];
            if (wr(5'd14)) m_epc <= bus.wdata_i;
            st_tmp = m_status;
            if (wr(5'd12)) st_tmp = (st_tmp & ~ST_MASK) | (bus.wdata_i & ST_MASK);
            if (bus.excepttype_i == 32'h0E) st_tmp[1] = 1'b0;
            else if (bus.excepttype_i != 0) st_tmp[1] = 1'b1;
            m_status <= st_tmp;
            if (bus.excepttype_i != 0 && bus.excepttype_i != 32'h0E) begin
                m_exc <= (bus.excepttype_i == 32'h1) ? 5'd0 : bus.excepttype_i[4:0];
                if (!m_status[1]) begin
                    m_epc <= bus.is_in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
                    m_bd  <= bus.is_in_delayslot_i;
                end
                if (bus.excepttype_i == 32'h4 || bus.excepttype_i == 32'h5)
                    m_bad <= bus.bad_addr_i;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            chk("count",    bus.count_o,           m_count());
            chk("compare",  bus.compare_o,         m_compare);
            chk("status",   bus.status_o,          m_status);
            chk("cause",    bus.cause_o,           m_cause());
            chk("epc",      bus.epc_o,             m_epc);
            chk("badvaddr", bus.badvaddr_o,        m_bad);
            chk("timer",    32'(bus.timer_int_o),  32'(m_tint));
            chk("rdata",    bus.rdata_o,           m_read(bus.raddr_i));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.raddr_i = rlist[ridx % 9];
        ridx++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
        tick();
        bus.we_i = 1'b0;
    endtask

    task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                       input logic [31:0] ba);
        bus.excepttype_i = t; bus.pc_i = pc; bus.is_in_delayslot_i = ds; bus.bad_addr_i = ba;
        tick();
        bus.excepttype_i = '0; bus.is_in_delayslot_i = 1'b0;
    endtask

    initial begin
        bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = '0;
        bus.int_i = '0; bus.excepttype_i = '0; bus.pc_i = '0;
        bus.is_in_delayslot_i = 1'b0; bus.bad_addr_i = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("lit_rst_status", bus.status_o, 32'h0040_0000);
        chk("lit_rst_count",  bus.count_o,  32'h0);
        chk("lit_rst_cause",  bus.cause_o,  32'h0);
        chk("lit_rst_timer",  32'(bus.timer_int_o), 32'h0);

        mtc0(5'd11, 32'h10);
        mtc0(5'd9,  32'h0);
        idle(33);
        chk("lit_cnt_match", bus.count_o, 32'h10);
        chk("lit_tint_set",  32'(bus.timer_int_o), 32'h1);
        idle(1);
        chk("lit_cause_ip7", 32'(bus.cause_o[15]), 32'h1);
        mtc0(5'd11, 32'h20);
        chk("lit_tint_clr",  32'(bus.timer_int_o), 32'h0);

        mtc0(5'd11, 32'h0);
        mtc0(5'd9,  32'hFFFF_FFFF);
        idle(2);
        chk("lit_cnt_wrap",  bus.count_o, 32'h0);
        idle(2);
        chk("lit_cmp0_nomatch", 32'(bus.timer_int_o), 32'h0);

        exc(32'h08, 32'hBFC0_1004, 1'b1, 32'h0);
        chk("lit_sys_epc",  bus.epc_o, 32'hBFC0_1000);
        chk("lit_sys_bd",   32'(bus.cause_o[31]), 32'h1);
        chk("lit_sys_code", 32'(bus.cause_o[6:2]), 32'h08);
        chk("lit_sys_exl",  32'(bus.status_o[1]), 32'h1);

        exc(32'h04, 32'h1234_5678, 1'b0, 32'h0000_0003);
        chk("lit_adel_bad",  bus.badvaddr_o, 32'h3);
        chk("lit_adel_code", 32'(bus.cause_o[6:2]), 32'h04);
        chk("lit_adel_epc",  bus.epc_o, 32'hBFC0_1000);

        bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.wdata_i = 32'h0000_FF03;
        exc(32'h0E, 32'h0, 1'b0, 32'h0);
        bus.we_i = 1'b0;
        chk("lit_eret_status", bus.status_o, 32'h0040_FF01);

        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("lit_cause_mask", bus.cause_o, 32'h8000_0310);
        mtc0(5'd8, 32'hDEAD_BEEF);
        chk("lit_bad_ro", bus.badvaddr_o, 32'h3);

        bus.int_i = 6'b100001;
        exc(32'h01, 32'h8000_0100, 1'b0, 32'h0);
        chk("lit_int_cause", bus.cause_o, 32'h0000_8700);
        chk("lit_int_epc",   bus.epc_o, 32'h8000_0100);
        bus.int_i = '0;

        exc(32'h13, 32'hAAAA_0000, 1'b0, 32'h0);
        chk("lit_unk_code", 32'(bus.cause_o[6:2]), 32'h13);
        chk("lit_unk_epc",  bus.epc_o, 32'h8000_0100);

        exc(32'h0E, 32'h0, 1'b0, 32'h0);
        bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h1111_0000;
        exc(32'h0C, 32'h2000_0008, 1'b0, 32'h0);
        bus.we_i = 1'b0;
        chk("lit_exc_over_mtc0", bus.epc_o, 32'h2000_0008);
        bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h3333_0000;
        exc(32'h0A, 32'h4000_0000, 1'b1, 32'h0);
        bus.we_i = 1'b0;
        chk("lit_nested_mtc0", bus.epc_o, 32'h3333_0000);

        mtc0(5'd11, 32'h5);
        mtc0(5'd9,  32'h5);
        tick();
        chk("lit_tint_pre_rst", 32'(bus.timer_int_o), 32'h1);
        #3 resetn = 1'b0;
        #1;
        chk("lit_mid_rst_status", bus.status_o, 32'h0040_0000);
        chk("lit_mid_rst_count",  bus.count_o,  32'h0);
        chk("lit_mid_rst_timer",  32'(bus.timer_int_o), 32'h0);
        chk("lit_mid_rst_epc",    bus.epc_o,    32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
